// File: rtl/isram_arb.sv
// Arbitrates the single-port instruction SRAM between fetch and an external port.
// Fetch has priority; starvation and locked bursts force external grants and stall fetch.
module isram_arb #(
    parameter int AW         = 29,
    parameter int DW         = 64,
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 16,
    parameter int CNTW       = 5
) (
    input  logic            clk,
    input  logic            cpurst,
    input  logic            fet_cs,
    input  logic [AW-1:0]   fet_adr,
    output logic            fet_arb_stall,
    output logic            fet_rvalid,
    input  logic            ext_req,
    input  logic            ext_we,
    input  logic            ext_lock,
    input  logic [AW-1:0]   ext_adr,
    input  logic [DW-1:0]   ext_wdata,
    input  logic [DW/8-1:0] ext_be,
    output logic            ext_gnt,
    output logic            ext_rvalid,
    output logic            sram_cs,
    output logic            sram_we,
    output logic [AW-1:0]   sram_adr,
    output logic [DW-1:0]   sram_wdata,
    output logic [DW/8-1:0] sram_be,
    input  logic [DW-1:0]   sram_rdata
);

    typedef enum logic {ARB_FET, ARB_LOCK} arb_state_t;

    localparam logic [CNTW-1:0] STARVE_LIM = CNTW'(STARVE_MAX);
    localparam logic [CNTW:0]   LOCK_LIM   = (CNTW+1)'(LOCK_MAX);

    arb_state_t      state;
    logic [CNTW-1:0] starve_cnt;
    logic [CNTW-1:0] lock_cnt;
    logic            pend_vld;
    logic [AW-1:0]   pend_adr;
    logic            force_gnt;
    logic            fet_issue;
    logic            lock_last;

    // Stall must stay independent of fet_cs: genpc derives fet_cs from the stall.
    assign force_gnt     = !cpurst && ext_req && (state == ARB_LOCK || starve_cnt == STARVE_LIM);
    assign fet_arb_stall = force_gnt;
    assign ext_gnt       = force_gnt || (!cpurst && ext_req && !fet_cs && !pend_vld);
    assign fet_issue     = !ext_gnt && (fet_cs || (pend_vld && !cpurst));
    // lock_cnt holds beats already taken, so this beat is number lock_cnt+1.
    assign lock_last     = ({1'b0, lock_cnt} + (CNTW+1)'(1)) >= LOCK_LIM;
    assign sram_wdata    = ext_wdata;

    always_comb begin
        sram_cs  = 1'b0;
        sram_we  = 1'b0;
        sram_adr = fet_adr;
        sram_be  = '1;
        if (ext_gnt) begin
            sram_cs  = 1'b1;
            sram_we  = ext_we;
            sram_adr = ext_adr;
            sram_be  = ext_be;
        end else if (fet_cs) begin
            sram_cs  = 1'b1;
        end else if (pend_vld && !cpurst) begin
            sram_cs  = 1'b1;
            sram_adr = pend_adr;
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state      <= ARB_FET;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            pend_vld   <= 1'b0;
            pend_adr   <= '0;
            fet_rvalid <= 1'b0;
            ext_rvalid <= 1'b0;
        end else begin
            fet_rvalid <= fet_issue;
            ext_rvalid <= ext_gnt && !ext_we;

            if (ext_gnt) begin
                if (fet_cs) begin
                    pend_vld <= 1'b1;
                    pend_adr <= fet_adr;
                end
            end else begin
                pend_vld <= 1'b0;
            end

            if (!ext_req || ext_gnt)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + CNTW'(1);

            case (state)
                ARB_FET: begin
                    if (ext_gnt && ext_lock) begin
                        state    <= ARB_LOCK;
                        lock_cnt <= CNTW'(1);
                    end
                end
                ARB_LOCK: begin
                    if (!ext_req || !ext_lock || lock_last) begin
                        state      <= ARB_FET;
                        lock_cnt   <= '0;
                        starve_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + CNTW'(1);
                    end
                end
                default: state <= ARB_FET;
            endcase
        end
    end

endmodule

// File: tb/tb_isram_arb.sv
// Vector-table bench for isram_arb; registered read valids are checked through a queue.
module tb_isram_arb;

    localparam int AW = 29;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            cpurst, fet_cs, ext_req, ext_we, ext_lock;
    logic [AW-1:0]   fet_adr, ext_adr, sram_adr;
    logic [DW-1:0]   ext_wdata, sram_wdata, sram_rdata;
    logic [DW/8-1:0] ext_be, sram_be;
    logic            fet_arb_stall, fet_rvalid, ext_gnt, ext_rvalid, sram_cs, sram_we;

    always #5 clk = ~clk;

    isram_arb #(.AW(AW), .DW(DW), .STARVE_MAX(8), .LOCK_MAX(16), .CNTW(5)) dut (
        .clk(clk), .cpurst(cpurst),
        .fet_cs(fet_cs), .fet_adr(fet_adr), .fet_arb_stall(fet_arb_stall), .fet_rvalid(fet_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_adr(ext_adr),
        .ext_wdata(ext_wdata), .ext_be(ext_be), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_adr(sram_adr), .sram_wdata(sram_wdata),
        .sram_be(sram_be), .sram_rdata(sram_rdata)
    );

    typedef struct {
        string      name;
        logic       rst, fcs, ereq, ewe, elock;
        logic [AW-1:0] fadr, eadr;
        logic [7:0] ebe;
        logic       x_stall, x_gnt, x_cs, x_we;
        logic [AW-1:0] x_adr;
        logic [7:0] x_be;
        logic       x_frv, x_erv;
    } vec_t;

    typedef struct {
        string name;
        logic  frv, erv;
    } rv_t;

    vec_t vq[$];
    rv_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input string n, input bit rst, fcs, input int fadr,
                       input bit ereq, ewe, elock, input int eadr, input int ebe,
                       input bit xs, xg, xc, xw, input int xa, input int xb,
                       input bit xf, xe);
        vec_t v;
        v.name = n; v.rst = rst; v.fcs = fcs; v.fadr = AW'(fadr);
        v.ereq = ereq; v.ewe = ewe; v.elock = elock; v.eadr = AW'(eadr); v.ebe = 8'(ebe);
        v.x_stall = xs; v.x_gnt = xg; v.x_cs = xc; v.x_we = xw;
        v.x_adr = AW'(xa); v.x_be = 8'(xb); v.x_frv = xf; v.x_erv = xe;
        vq.push_back(v);
    endtask

    task automatic idle();
        add("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] wdata_of(input logic [AW-1:0] a);
        return 64'hC0DE_0000_0000_0000 | 64'(a);
    endfunction

    initial begin
        int f;
        rv_t r;
        cpurst = 1'b1; fet_cs = 1'b0; fet_adr = '0; ext_req = 1'b0; ext_we = 1'b0;
        ext_lock = 1'b0; ext_adr = '0; ext_wdata = '0; ext_be = '0; sram_rdata = '0;

        add("reset", 1, 1, 'h5, 1, 0, 0, 'h9, 'hFF, 0, 0, 1, 0, 'h5, 'hFF, 0, 0);
        add("reset", 1, 1, 'h5, 1, 0, 0, 'h9, 'hFF, 0, 0, 1, 0, 'h5, 'hFF, 0, 0);
        add("fetch", 0, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h10, 'hFF, 1, 0);
        add("fetch", 0, 1, 'h11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h11, 'hFF, 1, 0);
        idle();
        add("ext_wr", 0, 0, 0, 1, 1, 0, 'h20, 'h0F, 0, 1, 1, 1, 'h20, 'h0F, 0, 0);
        idle();
        // starvation, forced read, replay, then ext blocked by replay for one slot
        for (int k = 0; k < 8; k++)
            add("starve_deny", 0, 1, 'h30 + k, 1, 0, 0, 'h40, 'hFF, 0, 0, 1, 0, 'h30 + k, 'hFF, 1, 0);
        add("starve_force", 0, 1, 'h38, 1, 0, 0, 'h40, 'hFF, 1, 1, 1, 0, 'h40, 'hFF, 0, 1);
        add("replay", 0, 0, 0, 1, 0, 0, 'h41, 'hFF, 0, 0, 1, 0, 'h38, 'hFF, 1, 0);
        add("ext_after_replay", 0, 0, 0, 1, 0, 0, 'h41, 'hFF, 0, 1, 1, 0, 'h41, 'hFF, 0, 1);
        idle();
        // pending replay overridden by a new fetch address
        for (int k = 0; k < 8; k++)
            add("simul_deny", 0, 1, 'h50 + k, 1, 0, 0, 'h60, 'hFF, 0, 0, 1, 0, 'h50 + k, 'hFF, 1, 0);
        add("simul_force", 0, 1, 'h58, 1, 0, 0, 'h60, 'hFF, 1, 1, 1, 0, 'h60, 'hFF, 0, 1);
        add("replay_override", 0, 1, 'h59, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h59, 'hFF, 1, 0);
        idle();
        // 20-beat locked write burst against continuous fetch
        f = 'h100;
        for (int k = 0; k < 8; k++) begin
            add("lock_deny", 0, 1, f, 1, 1, 1, 'h200, 'hAA, 0, 0, 1, 0, f, 'hFF, 1, 0);
            f++;
        end
        for (int b = 0; b < 16; b++)
            add("lock_beat", 0, 1, f, 1, 1, 1, 'h200 + b, 'hAA, 1, 1, 1, 1, 'h200 + b, 'hAA, 0, 0);
        for (int k = 0; k < 8; k++) begin
            add("post_release_fetch", 0, 1, f, 1, 1, 1, 'h210, 'hAA, 0, 0, 1, 0, f, 'hFF, 1, 0);
            f++;
        end
        for (int b = 16; b < 20; b++)
            add("lock_resume", 0, 1, f, 1, 1, (b != 19), 'h200 + b, 'hAA, 1, 1, 1, 1, 'h200 + b, 'hAA, 0, 0);
        add("after_burst", 0, 1, f, 1, 0, 0, 'h220, 'hFF, 0, 0, 1, 0, f, 'hFF, 1, 0);
        idle();
        // reset in the middle of a locked burst
        add("lock_enter", 0, 0, 0, 1, 0, 1, 'h300, 'hFF, 0, 1, 1, 0, 'h300, 'hFF, 0, 1);
        add("lock_forced", 0, 1, 'h77, 1, 0, 1, 'h301, 'hFF, 1, 1, 1, 0, 'h301, 'hFF, 0, 1);
        add("rst_midlock", 1, 1, 'h77, 1, 0, 1, 'h302, 'hFF, 0, 0, 1, 0, 'h77, 'hFF, 0, 0);
        add("post_rst_nopend", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("post_rst_state", 0, 1, 'h78, 1, 0, 1, 'h302, 'hFF, 0, 0, 1, 0, 'h78, 'hFF, 1, 0);
        idle();
        idle();

        @(posedge clk);
        #1;
        foreach (vq[i]) begin
            cpurst   = vq[i].rst;
            fet_cs   = vq[i].fcs;
            fet_adr  = vq[i].fadr;
            ext_req  = vq[i].ereq;
            ext_we   = vq[i].ewe;
            ext_lock = vq[i].elock;
            ext_adr  = vq[i].eadr;
            ext_be   = vq[i].ebe;
            ext_wdata = wdata_of(vq[i].eadr);
            sram_rdata = 64'(i);
            #1;
            chk({vq[i].name, ".stall"}, 64'(fet_arb_stall), 64'(vq[i].x_stall));
            chk({vq[i].name, ".gnt"},   64'(ext_gnt),       64'(vq[i].x_gnt));
            chk({vq[i].name, ".cs"},    64'(sram_cs),       64'(vq[i].x_cs));
            chk({vq[i].name, ".we"},    64'(sram_we),       64'(vq[i].x_we));
            if (vq[i].x_cs) begin
                chk({vq[i].name, ".adr"}, 64'(sram_adr), 64'(vq[i].x_adr));
                chk({vq[i].name, ".be"},  64'(sram_be),  64'(vq[i].x_be));
            end
            if (vq[i].x_gnt && vq[i].x_we)
                chk({vq[i].name, ".wdata"}, sram_wdata, wdata_of(vq[i].eadr));
            r.name = vq[i].name; r.frv = vq[i].x_frv; r.erv = vq[i].x_erv;
            sb.push_back(r);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 64'(1), 64'(0));
            end else begin
                r = sb.pop_front();
                chk({r.name, ".fet_rvalid"}, 64'(fet_rvalid), 64'(r.frv));
                chk({r.name, ".ext_rvalid"}, 64'(ext_rvalid), 64'(r.erv));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
